// File: rtl/alu_logic_pkg.sv
// alu_logic_pkg: shared op codes, FSM states and default width for the serial logic unit (optional LOGIC_PARITY_EN)
package alu_logic_pkg;

    localparam int DEFAULT_SIZE = 16;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_logic_unit_if.sv
// serial_logic_unit_if: bit-serial operand link and parallel result port; out_parity exists only with LOGIC_PARITY_EN
interface serial_logic_unit_if
    import alu_logic_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
);

    logic            in_valid;
    logic            in_ready;
    logic            in_a_bit;
    logic            in_b_bit;
    logic [1:0]      in_op;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_r;
`ifdef LOGIC_PARITY_EN
    logic            out_parity;
`endif

    // Producer of bit pairs and consumer of results
    modport master (
        output in_valid, in_a_bit, in_b_bit, in_op, out_ready,
        input  in_ready, out_valid, out_r
`ifdef LOGIC_PARITY_EN
        , input out_parity
`endif
    );

    // The logic unit itself
    modport slave (
        input  in_valid, in_a_bit, in_b_bit, in_op, out_ready,
        output in_ready, out_valid, out_r
`ifdef LOGIC_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/logic_op_slice.sv
// logic_op_slice: combinational SIZE-bit OR/AND/XOR/NOR unit (shared by builds with and without LOGIC_PARITY_EN)
module logic_op_slice
    import alu_logic_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [1:0]      op,
    output logic [SIZE-1:0] r
);

    // Select the bitwise function; NOR is the fall-through code
    always_comb
        r = (op == OP_OR)  ? (a | b) :
            (op == OP_AND) ? (a & b) :
            (op == OP_XOR) ? (a ^ b) :
                             ~(a | b);

endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: LSB-first bit-serial operand receiver feeding a bitwise logic unit; LOGIC_PARITY_EN adds out_parity
module serial_logic_unit
    import alu_logic_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input logic               clk,
    input logic               rst_n,
    serial_logic_unit_if.slave bus
);

    localparam int             CW   = $clog2(SIZE + 1);
    localparam logic [CW-1:0]  LAST = CW'(SIZE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] sh_a;
    logic [SIZE-1:0] sh_b;
    logic [SIZE-1:0] a_nxt;
    logic [SIZE-1:0] b_nxt;
    logic [SIZE-1:0] r;
    logic [SIZE-1:0] out_r_q;
    logic [1:0]      op_q;
    logic            out_valid_q;
    logic            in_ready;
    logic            accept;
    logic            last;
    logic            release_hold;

    // New bits enter at the MSB so that bit k ends up holding the k-th bit received
    assign a_nxt = {bus.in_a_bit, sh_a[SIZE-1:1]};
    assign b_nxt = {bus.in_b_bit, sh_b[SIZE-1:1]};

    // Operates on the post-shift operands so the result is ready on the final accept edge
    logic_op_slice #(.SIZE(SIZE)) u_slice (
        .a  (a_nxt),
        .b  (b_nxt),
        .op (op_q),
        .r  (r)
    );

    // State register
    always_ff @(posedge clk)
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;

    // Next-state: start on first accept, finish on SIZE-th accept, release on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? S_SHIFT : S_IDLE;
            S_SHIFT: state_nxt = last ? S_HOLD : S_SHIFT;
            S_HOLD:  state_nxt = bus.out_ready ? S_IDLE : S_HOLD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decodes: in_ready comes straight from state, the rest qualify datapath updates
    always_comb begin
        in_ready     = (state != S_HOLD);
        accept       = bus.in_valid && in_ready;
        last         = accept && (state == S_SHIFT) && (cnt == LAST);
        release_hold = (state == S_HOLD) && bus.out_ready;
    end

    // Datapath: shift registers, bit count, latched op and registered result
    always_ff @(posedge clk)
        if (!rst_n) begin
            sh_a        <= '0;
            sh_b        <= '0;
            cnt         <= '0;
            op_q        <= OP_OR;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                sh_a <= a_nxt;
                sh_b <= b_nxt;
                cnt  <= cnt + CW'(1);
            end
            if (accept && state == S_IDLE)
                op_q <= bus.in_op;
            if (last) begin
                out_r_q     <= r;
                out_valid_q <= 1'b1;
            end
            if (release_hold) begin
                out_valid_q <= 1'b0;
                cnt         <= '0;
            end
        end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;

`ifdef LOGIC_PARITY_EN
    logic parity_q;

    // Parity is captured on the same edge as the result it describes
    always_ff @(posedge clk)
        if (!rst_n)
            parity_q <= 1'b0;
        else if (last)
            parity_q <= ^r;

    assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: directed and randomized checks of serial_logic_unit (parity checked when LOGIC_PARITY_EN is defined)
module tb_serial_logic_unit;

    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_logic_unit_if #(.SIZE(N)) bus ();

    serial_logic_unit #(.SIZE(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference: the op applied bit by bit to whole operands
    function automatic logic [N-1:0] ref_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++)
            case (op)
                2'd0: r[k] = a[k] | b[k];
                2'd1: r[k] = a[k] & b[k];
                2'd2: r[k] = a[k] ^ b[k];
                default: r[k] = ~(a[k] | b[k]);
            endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: optional stall before bit stall_at, garbage ops after bit 0, bp cycles of backpressure
    task automatic frame(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [1:0] op, input logic [1:0] op_mid,
                         input int stall_at, input int stall_len, input int bp);
        logic [N-1:0] exp;
        exp = ref_op(op, a, b);
        for (int i = 0; i < N; i++) begin
            if (i == stall_at)
                for (int s = 0; s < stall_len; s++) begin
                    bus.in_valid = 1'b0;
                    bus.in_a_bit = 1'($urandom());
                    bus.in_b_bit = 1'($urandom());
                    @(negedge clk);
                    chk({tag, " stall_valid"}, bus.out_valid, 0);
                end
            chk({tag, " ready"}, bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_a_bit = a[i];
            bus.in_b_bit = b[i];
            bus.in_op    = (i == 0) ? op : op_mid;
            @(negedge clk);
            if (i < N - 1)
                chk({tag, " early_valid"}, bus.out_valid, 0);
        end
        bus.in_a_bit = 1'($urandom());
        bus.in_b_bit = 1'($urandom());
        chk({tag, " valid"}, bus.out_valid, 1);
        chk({tag, " r"}, bus.out_r, exp);
        chk({tag, " hold_ready"}, bus.in_ready, 0);
`ifdef LOGIC_PARITY_EN
        chk({tag, " parity"}, bus.out_parity, ^exp);
`endif
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk({tag, " bp_valid"}, bus.out_valid, 1);
            chk({tag, " bp_r"}, bus.out_r, exp);
            chk({tag, " bp_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " released"}, bus.out_valid, 0);
        chk({tag, " idle_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a_bit  = 1'b0;
        bus.in_b_bit  = 1'b0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset valid", bus.out_valid, 0);
        chk("reset r", bus.out_r, 0);
        chk("reset ready", bus.in_ready, 1);
`ifdef LOGIC_PARITY_EN
        chk("reset parity", bus.out_parity, 0);
`endif
        frame("or",  16'd248, 16'd327, 2'b00, 2'b00, -1, 0, 0);
        frame("and", 16'd248, 16'd327, 2'b01, 2'b01, -1, 0, 0);
        frame("xor", 16'd248, 16'd327, 2'b10, 2'b10, -1, 0, 0);
        frame("nor", 16'd248, 16'd327, 2'b11, 2'b11, -1, 0, 0);
        frame("stall", 16'd248, 16'd327, 2'b00, 2'b00, 8, 3, 0);
        frame("backpressure", 16'd248, 16'd327, 2'b00, 2'b00, -1, 0, 5);
        frame("opchange", 16'd248, 16'd327, 2'b00, 2'b01, -1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a_bit = 1'($urandom());
            bus.in_b_bit = 1'($urandom());
            bus.in_op    = 2'b00;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset valid", bus.out_valid, 0);
        chk("midreset r", bus.out_r, 0);
        chk("midreset ready", bus.in_ready, 1);
`ifdef LOGIC_PARITY_EN
        chk("midreset parity", bus.out_parity, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midreset no_valid", bus.out_valid, 0);
        end
        frame("post_reset_xor", 16'd248, 16'd327, 2'b10, 2'b10, -1, 0, 0);
        for (int f = 0; f < 24; f++) begin
            ra = N'($urandom());
            rb = N'($urandom());
            frame("random", ra, rb, 2'($urandom()), 2'($urandom()),
                  $urandom_range(0, 24), $urandom_range(1, 4), $urandom_range(0, 3));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
